// File: rtl/mpsoc_boot_sequencer.sv
// Boot sequencer for mor1k_mpsoc: holds the SoC in reset, waits for all tile RAMs,
// then raises processors_en and releases tile CPU enables one at a time.
module mpsoc_boot_sequencer #(
  parameter int TILE_NUM        = 4,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int STAGGER_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sw_restart,
  input  logic [TILE_NUM-1:0] ram_ready,
  output logic                soc_reset,
  output logic                processors_en,
  output logic [TILE_NUM-1:0] tile_en,
  output logic                boot_done,
  output logic                boot_err
);

  localparam int MAX_A   = (RST_HOLD_CYCLES > STAGGER_CYCLES) ? RST_HOLD_CYCLES : STAGGER_CYCLES;
  localparam int MAX_CNT = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0]    HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]    STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TILE_NUM-1:0] TILE0        = TILE_NUM'(1);

  typedef enum logic [2:0] {
    RST_HOLD,
    WAIT_MEM,
    STAGGER,
    RUN,
    ERROR
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                soc_reset_n, processors_en_n, boot_done_n, boot_err_n;
  logic [TILE_NUM-1:0] tile_en_n;
  logic [TILE_NUM-1:0] next_tile;
  logic [1:0]          rel_sync;
  logic                held;

  // Reset release is resynchronised; the sequencer stays frozen until it clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rel_sync <= 2'b11;
    else       rel_sync <= {rel_sync[0], 1'b0};
  end

  assign held      = rel_sync[1];
  assign next_tile = (tile_en << 1) | TILE0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= RST_HOLD;
      cnt           <= '0;
      soc_reset     <= 1'b1;
      processors_en <= 1'b0;
      tile_en       <= '0;
      boot_done     <= 1'b0;
      boot_err      <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      soc_reset     <= soc_reset_n;
      processors_en <= processors_en_n;
      tile_en       <= tile_en_n;
      boot_done     <= boot_done_n;
      boot_err      <= boot_err_n;
    end
  end

  always_comb begin
    state_n         = state;
    cnt_n           = cnt;
    soc_reset_n     = soc_reset;
    processors_en_n = processors_en;
    tile_en_n       = tile_en;
    boot_done_n     = boot_done;
    boot_err_n      = boot_err;

    if (!held) begin
      if (sw_restart) begin
        state_n         = RST_HOLD;
        cnt_n           = '0;
        soc_reset_n     = 1'b1;
        processors_en_n = 1'b0;
        tile_en_n       = '0;
        boot_done_n     = 1'b0;
        boot_err_n      = 1'b0;
      end else begin
        unique case (state)
          RST_HOLD: begin
            soc_reset_n     = 1'b1;
            processors_en_n = 1'b0;
            tile_en_n       = '0;
            if (cnt == HOLD_LAST) begin
              soc_reset_n = 1'b0;
              cnt_n       = '0;
              state_n     = WAIT_MEM;
            end else begin
              cnt_n = cnt + CNT_W'(1);
            end
          end
          WAIT_MEM: begin
            // All-ready takes priority over a timeout landing on the same edge.
            if (&ram_ready) begin
              processors_en_n = 1'b1;
              tile_en_n       = TILE0;
              cnt_n           = '0;
              if (TILE_NUM == 1) begin
                boot_done_n = 1'b1;
                state_n     = RUN;
              end else begin
                state_n = STAGGER;
              end
            end else if (cnt == TIMEOUT_LAST) begin
              boot_err_n = 1'b1;
              cnt_n      = '0;
              state_n    = ERROR;
            end else begin
              cnt_n = cnt + CNT_W'(1);
            end
          end
          STAGGER: begin
            if (cnt == STAGGER_LAST) begin
              tile_en_n = next_tile;
              cnt_n     = '0;
              if (next_tile[TILE_NUM-1]) begin
                boot_done_n = 1'b1;
                state_n     = RUN;
              end
            end else begin
              cnt_n = cnt + CNT_W'(1);
            end
          end
          RUN: begin
          end
          ERROR: begin
            soc_reset_n     = 1'b0;
            processors_en_n = 1'b0;
            tile_en_n       = '0;
            boot_err_n      = 1'b1;
          end
          default: begin
            state_n = RST_HOLD;
            cnt_n   = '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mpsoc_boot_sequencer.sv
// Bench for mpsoc_boot_sequencer: timeline reference model plus directed and random steps.
module tb_mpsoc_boot_sequencer;
  localparam int N  = 4;
  localparam int RH = 16;
  localparam int SC = 4;
  localparam int TO = 1024;

  logic         clk = 1'b0;
  logic         reset;
  logic         sw_restart;
  logic [N-1:0] ram_ready;
  logic         soc_reset;
  logic         processors_en;
  logic [N-1:0] tile_en;
  logic         boot_done;
  logic         boot_err;

  int checks   = 0;
  int failures = 0;

  // Reference timeline: edge count since release, edge where soc_reset falls,
  // edge where all RAMs were seen ready (-1 = not yet), and sticky timeout flag.
  int e;
  int soc_fall;
  int rdy_e;
  bit err_m;

  mpsoc_boot_sequencer #(
    .TILE_NUM(N), .RST_HOLD_CYCLES(RH), .STAGGER_CYCLES(SC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .sw_restart(sw_restart), .ram_ready(ram_ready),
    .soc_reset(soc_reset), .processors_en(processors_en), .tile_en(tile_en),
    .boot_done(boot_done), .boot_err(boot_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e        = 0;
      soc_fall = RH + 2;
      rdy_e    = -1;
      err_m    = 1'b0;
    end else begin
      e = e + 1;
      if (sw_restart) begin
        soc_fall = e + RH;
        rdy_e    = -1;
        err_m    = 1'b0;
      end else if (rdy_e < 0 && !err_m && e > soc_fall) begin
        if (&ram_ready)             rdy_e = e;
        else if (e == soc_fall + TO) err_m = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, exp_v, e);
    end
  endtask

  task automatic check_all();
    logic [N-1:0] te_x;
    for (int k = 0; k < N; k++) te_x[k] = (rdy_e >= 0) && (e >= rdy_e + k * SC);
    chk("soc_reset",     32'(soc_reset),     32'(e < soc_fall));
    chk("processors_en", 32'(processors_en), 32'(rdy_e >= 0));
    chk("tile_en",       32'(tile_en),       32'(te_x));
    chk("boot_done",     32'(boot_done),     32'((rdy_e >= 0) && (e >= rdy_e + (N - 1) * SC)));
    chk("boot_err",      32'(boot_err),      32'(err_m));
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_e(input int target);
    int g = 0;
    while (e < target && g < 5000) begin
      step();
      g++;
    end
    if (e < target) chk("wait_bound", 32'(e), 32'(target));
  endtask

  task automatic pulse_restart(output int r);
    sw_restart = 1'b1;
    step();
    sw_restart = 1'b0;
    r = e;
  endtask

  initial begin
    int r;
    int g;
    reset      = 1'b1;
    sw_restart = 1'b0;
    ram_ready  = '0;
    #1;
    check_all();
    chk("reset_soc", 32'(soc_reset), 32'd1);
    repeat (3) step();

    // Nominal boot
    @(negedge clk);
    reset     = 1'b0;
    ram_ready = 4'hF;
    wait_e(17); chk("nom_soc_17", 32'(soc_reset), 32'd1);
    wait_e(18); chk("nom_soc_18", 32'(soc_reset), 32'd0);
    wait_e(19); chk("nom_pe_19", 32'(processors_en), 32'd1);
    chk("nom_te_19", 32'(tile_en), 32'h1);
    wait_e(23); chk("nom_te_23", 32'(tile_en), 32'h3);
    wait_e(27); chk("nom_te_27", 32'(tile_en), 32'h7);
    wait_e(30); chk("nom_done_30", 32'(boot_done), 32'd0);
    wait_e(31); chk("nom_te_31", 32'(tile_en), 32'hF);
    chk("nom_done_31", 32'(boot_done), 32'd1);
    for (int i = 0; i < 10; i++) begin
      ram_ready = N'($urandom);
      step();
    end

    // Restart mid-stagger
    ram_ready = 4'hF;
    pulse_restart(r);
    g = 0;
    while (!(rdy_e >= 0 && e == rdy_e + SC) && g < 200) begin
      step();
      g++;
    end
    chk("mid_te_0011", 32'(tile_en), 32'h3);
    pulse_restart(r);
    chk("mid_soc", 32'(soc_reset), 32'd1);
    chk("mid_te", 32'(tile_en), 32'h0);
    chk("mid_pe", 32'(processors_en), 32'd0);
    wait_e(r + RH - 1); chk("mid_soc_hold", 32'(soc_reset), 32'd1);
    wait_e(r + RH);     chk("mid_soc_fall", 32'(soc_reset), 32'd0);
    wait_e(r + RH + 1 + (N - 1) * SC); chk("mid_done", 32'(boot_done), 32'd1);

    // Random ram_ready patterns across several restarts
    for (int n = 0; n < 5; n++) begin
      pulse_restart(r);
      for (int i = 0; i < 70; i++) begin
        ram_ready = ($urandom_range(0, 3) == 0) ? N'($urandom) : N'(4'hF ^ (1 << $urandom_range(0, N - 1)));
        if (i > 40 + n) ram_ready = 4'hF;
        step();
      end
    end

    // Timeout, then late ready is ignored
    ram_ready = 4'b0111;
    pulse_restart(r);
    wait_e(r + RH + TO - 1); chk("to_err_before", 32'(boot_err), 32'd0);
    wait_e(r + RH + TO);     chk("to_err", 32'(boot_err), 32'd1);
    chk("to_pe", 32'(processors_en), 32'd0);
    ram_ready = 4'hF;
    repeat (20) step();
    chk("to_late_pe", 32'(processors_en), 32'd0);
    chk("to_late_te", 32'(tile_en), 32'h0);
    chk("to_late_err", 32'(boot_err), 32'd1);

    // Restart from ERROR
    pulse_restart(r);
    chk("err_clear", 32'(boot_err), 32'd0);
    chk("err_soc", 32'(soc_reset), 32'd1);
    wait_e(r + RH);     chk("err_soc_fall", 32'(soc_reset), 32'd0);
    wait_e(r + RH + 1); chk("err_te", 32'(tile_en), 32'h1);
    wait_e(r + RH + 1 + (N - 1) * SC); chk("err_done", 32'(boot_done), 32'd1);

    // Ready arrives on the timeout edge
    ram_ready = 4'b1011;
    pulse_restart(r);
    wait_e(r + RH + TO - 1);
    ram_ready = 4'hF;
    step();
    chk("col_pe", 32'(processors_en), 32'd1);
    chk("col_err", 32'(boot_err), 32'd0);
    wait_e(r + RH + TO + (N - 1) * SC); chk("col_done", 32'(boot_done), 32'd1);

    // Asynchronous reset in RUN, between edges
    repeat (5) step();
    #2 reset = 1'b1;
    #1;
    chk("ar_soc", 32'(soc_reset), 32'd1);
    chk("ar_pe", 32'(processors_en), 32'd0);
    chk("ar_te", 32'(tile_en), 32'h0);
    chk("ar_done", 32'(boot_done), 32'd0);
    check_all();
    repeat (2) step();
    reset = 1'b0;
    wait_e(18); chk("ar_soc_fall", 32'(soc_reset), 32'd0);
    wait_e(31); chk("ar_done_again", 32'(boot_done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
